distributor_replay: RTL and testbench
=====================================

Name: distributor_replay

Overview:
- Stimulus transmitter for the parser lanes that normally sit behind the distributor.
- Holds a small table of slice records, loaded through a config write port.
- On start, replays the records as distributor-format beats: 144-bit data plus token_pos, address, garbage and start_lit, with a one-hot per-lane valid.
- Each beat is held until the target lane accepts it. Used in bring-up and regression to drive parser lanes without a live distributor upstream.

Parameters:
- LANES, 6, number of downstream lanes (width of valid / lane_ready).
- DEPTH, 16, record table entries (power of 2).
- AW, 4, log2(DEPTH).
- TIMEOUT, 255, maximum stall cycles per beat before abort with error.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, synchronous, active-low.
- cfg_we  input  1  record table write strobe.
- cfg_addr  input  AW  record table write index.
- cfg_data  input  181  record: [180:37] data, [36:21] token_pos, [20:4] address, [3:1] garbage, [0] start_lit.
- start  input  1  begin replay (pulse).
- num_rec  input  AW+1  number of records to replay, 0..DEPTH.
- lane_ready  input  LANES  per-lane accept.
- data_out  output  144  beat payload.
- token_pos  output  16  token position field.
- address  output  17  slice address.
- garbage  output  3  garbage byte count.
- start_lit  output  1  slice begins inside a literal.
- valid  output  LANES  one-hot target lane; all zero when idle.
- busy  output  1  replay in progress.
- done  output  1  one-cycle pulse at end of replay.
- error  output  1  sticky stall-timeout flag; cleared by the next accepted start.
- beat_cnt  output  AW+1  beats accepted so far.
- state_out  output  4  FSM state delayed one cycle, for probing.

Behaviour:
- Reset: all outputs 0. FSM goes to IDLE, lane pointer 0, counters 0. Table contents are not reset and survive reset.
- Table writes: cfg_we is honoured only in IDLE and writes mem[cfg_addr] at the clock edge. It is ignored while busy.
- FSM encoding: IDLE=0, FETCH=1, ISSUE=2, DONE=3.
- IDLE, start=1:
  - Capture num_rec; clear beat_cnt and error; set busy.
  - num_rec=0: go to DONE.
  - Otherwise: go to FETCH with record index 0 and lane 0.
  - start is ignored in all states other than IDLE.
- FETCH (1 cycle):
  - Register mem[idx] onto data_out/token_pos/address/garbage/start_lit.
  - Set valid = 1<<lane.
  - Clear stall counter; go to ISSUE.
- ISSUE:
  - Outputs and valid are held stable.
  - Transfer occurs on a cycle where lane_ready[lane]=1. Readiness of other lanes is ignored.
  - On transfer:
    - valid is 0 next cycle; payload outputs go to 0 next cycle.
    - beat_cnt+1; idx+1.
    - lane = lane+1, wrapping LANES-1 -> 0.
    - If beat_cnt+1 == num_rec, go to DONE; otherwise go to FETCH.
  - Throughput: at most one beat every 2 cycles.
  - No transfer: stall counter +1. When it reaches TIMEOUT, set error, clear valid, go to DONE.
- DONE (1 cycle): done=1, busy=0, then IDLE.
- num_rec > DEPTH is clamped to DEPTH.
- state_out = FSM state registered one extra cycle.
- Reset asserted mid-replay: valid drops on the next edge and no further beats are issued.

Test Plan:
- Load record 0 = {data 144'h040d0a090200203a01007c414c4943000000, token_pos 16'h9520, address 17'h00000, garbage 3'h3, start_lit 0}. start with num_rec=1, lane_ready=6'h3F.
  -> valid=6'h01 with exact fields for 1 cycle; done pulse 2 cycles after valid; beat_cnt=1; error=0.
- Load 6 records (second one: data 144'h494345275320414456454e54555245532049, address 17'h0001a, start_lit 1). num_rec=6, all ready.
  -> valid sequence 01,02,04,08,10,20 on alternate cycles; beat_cnt=6; busy is high for 13 cycles.
- num_rec=8, LANES=6.
  -> beats 7 and 8 go to lanes 0 and 1 (valid 6'h01, 6'h02).
- lane_ready[1] held low for 10 cycles during beat 2.
  -> valid=6'h02 and payload stable all 10 cycles; transfer on first cycle ready=1; ready on other lanes does not complete the beat.
- TIMEOUT=255 with lane_ready=0 throughout.
  -> error=1 after 255 stall cycles; valid clears; done pulses; next start clears error.
- Edge cases:
  - num_rec=0 -> done pulses with no valid.
  - rst_n low mid-replay -> all outputs 0 next cycle.
  - cfg_we while busy -> table unchanged, confirmed by a second replay.

Source files
------------

// File: rtl/distributor_replay.sv
// Replays a small table of distributor-format slice records onto parser lanes.
// Each beat goes to the next lane round-robin and is held until that lane accepts it.
module distributor_replay #(
  parameter int unsigned LANES   = 6,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned AW      = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [180:0]     cfg_data,
  input  logic             start,
  input  logic [AW:0]      num_rec,
  input  logic [LANES-1:0] lane_ready,
  output logic [143:0]     data_out,
  output logic [15:0]      token_pos,
  output logic [16:0]      address,
  output logic [2:0]       garbage,
  output logic             start_lit,
  output logic [LANES-1:0] valid,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [AW:0]      beat_cnt,
  output logic [3:0]       state_out
);

  localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned SW = $clog2(TIMEOUT + 1);

  localparam logic [LANES-1:0] LaneOne    = LANES'(1);
  localparam logic [LW-1:0]    LastLane   = LW'(LANES - 1);
  localparam logic [AW:0]      DepthVal   = (AW + 1)'(DEPTH);
  localparam logic [SW-1:0]    TimeoutCnt = SW'(TIMEOUT);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StIssue = 2'd2,
    StDone  = 2'd3
  } state_e;

  // Table is intentionally not reset so it survives a reset between replays.
  logic [180:0] mem [DEPTH];

  state_e           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [LW-1:0]    lane_q, lane_d;
  logic [AW:0]      num_q, num_d;
  logic [AW:0]      beat_q, beat_d;
  logic [SW-1:0]    stall_q, stall_d;
  logic [180:0]     rec_q, rec_d;
  logic [LANES-1:0] valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [3:0]       state_dly_q;

  logic [AW:0]      beat_inc;
  logic [SW-1:0]    stall_inc;

  assign beat_inc  = beat_q + 1'b1;
  assign stall_inc = stall_q + 1'b1;

  always_ff @(posedge clk) begin
    if (cfg_we && (state_q == StIdle)) begin
      mem[cfg_addr] <= cfg_data;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    num_d   = num_q;
    beat_d  = beat_q;
    stall_d = stall_q;
    rec_d   = rec_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    error_d = error_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          num_d   = (num_rec > DepthVal) ? DepthVal : num_rec;
          beat_d  = '0;
          error_d = 1'b0;
          busy_d  = 1'b1;
          idx_d   = '0;
          lane_d  = '0;
          state_d = (num_rec == '0) ? StDone : StFetch;
        end
      end

      StFetch: begin
        rec_d   = mem[idx_q];
        valid_d = LaneOne << lane_q;
        stall_d = '0;
        state_d = StIssue;
      end

      StIssue: begin
        if (lane_ready[lane_q]) begin
          valid_d = '0;
          rec_d   = '0;
          beat_d  = beat_inc;
          idx_d   = idx_q + 1'b1;
          lane_d  = (lane_q == LastLane) ? '0 : lane_q + 1'b1;
          state_d = (beat_inc == num_q) ? StDone : StFetch;
        end else begin
          stall_d = stall_inc;
          if (stall_inc == TimeoutCnt) begin
            error_d = 1'b1;
            valid_d = '0;
            rec_d   = '0;
            state_d = StDone;
          end
        end
      end

      StDone: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      lane_q      <= '0;
      num_q       <= '0;
      beat_q      <= '0;
      stall_q     <= '0;
      rec_q       <= '0;
      valid_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      state_dly_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      lane_q      <= lane_d;
      num_q       <= num_d;
      beat_q      <= beat_d;
      stall_q     <= stall_d;
      rec_q       <= rec_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      state_dly_q <= {2'b00, state_q};
    end
  end

  assign data_out  = rec_q[180:37];
  assign token_pos = rec_q[36:21];
  assign address   = rec_q[20:4];
  assign garbage   = rec_q[3:1];
  assign start_lit = rec_q[0];
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign beat_cnt  = beat_q;
  assign state_out = state_dly_q;

endmodule

// File: tb/tb_distributor_replay.sv
// Randomized directed bench for distributor_replay, checked against a beat-level model:
// beat k carries table entry k to lane k mod LANES, one beat per accepted handshake.
module tb_distributor_replay;
  localparam int LANES   = 6;
  localparam int DEPTH   = 16;
  localparam int AW      = 4;
  localparam int TIMEOUT = 255;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_we = 1'b0;
  logic [AW-1:0]    cfg_addr = '0;
  logic [180:0]     cfg_data = '0;
  logic             start = 1'b0;
  logic [AW:0]      num_rec = '0;
  logic [LANES-1:0] lane_ready = '0;
  logic [143:0]     data_out;
  logic [15:0]      token_pos;
  logic [16:0]      address;
  logic [2:0]       garbage;
  logic             start_lit;
  logic [LANES-1:0] valid;
  logic             busy;
  logic             done;
  logic             error;
  logic [AW:0]      beat_cnt;
  logic [3:0]       state_out;

  int vectors = 0;
  int miscompares = 0;
  logic [180:0] ref_mem [DEPTH];

  distributor_replay #(
    .LANES(LANES), .DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .num_rec(num_rec), .lane_ready(lane_ready), .data_out(data_out),
    .token_pos(token_pos), .address(address), .garbage(garbage), .start_lit(start_lit),
    .valid(valid), .busy(busy), .done(done), .error(error), .beat_cnt(beat_cnt),
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [180:0] obs, input logic [180:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [180:0] rand_rec();
    logic [180:0] r = '0;
    for (int i = 0; i < 6; i++) r = {r[148:0], 32'($urandom())};
    return r;
  endfunction

  function automatic logic [180:0] payload();
    return {data_out, token_pos, address, garbage, start_lit};
  endfunction

  // Only called while the DUT is idle, so the write must land.
  task automatic load(input int a, input logic [180:0] r);
    cfg_we = 1'b1;
    cfg_addr = a[AW-1:0];
    cfg_data = r;
    @(negedge clk);
    cfg_we = 1'b0;
    ref_mem[a] = r;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 181'(valid), '0);
    chk({tag, "_payload"}, payload(), '0);
    chk({tag, "_flags"}, 181'({busy, done, error}), '0);
    chk({tag, "_beat_cnt"}, 181'(beat_cnt), '0);
    chk({tag, "_state_out"}, 181'(state_out), '0);
  endtask

  // mode: 0 all ready, 1 random ready, 2 hold lane 1 off for 10 cycles on beat 2,
  // 3 never ready, 4 all ready with table writes issued while busy.
  task automatic replay(input int n, input int mode, output int stalls);
    int ne, k, consec, busy_cyc, last_xfer, done_cyc, hold;
    bit xfer_prev, timed_out;
    logic [LANES-1:0] exp_v;
    ne = (n > DEPTH) ? DEPTH : n;
    k = 0; consec = 0; busy_cyc = 0; last_xfer = 0; done_cyc = 0; hold = 0; stalls = 0;
    xfer_prev = 1'b0; timed_out = 1'b0;
    start = 1'b1;
    num_rec = n[AW:0];
    @(negedge clk);
    start = 1'b0;
    chk("error_cleared_on_start", 181'(error), '0);
    for (int cyc = 1; cyc <= 2000; cyc++) begin
      if (busy) busy_cyc++;
      if (done) begin
        done_cyc = cyc;
        chk("valid_at_done", 181'(valid), '0);
        break;
      end
      if (xfer_prev || timed_out) chk("valid_drop", 181'(valid), '0);
      if (xfer_prev) chk("payload_drop", payload(), '0);
      xfer_prev = 1'b0;
      if (valid !== '0 && k >= ne) begin
        chk("extra_beat", 181'(valid), '0);
        lane_ready = '0;
      end else if (valid !== '0) begin
        exp_v = LANES'(1) << (k % LANES);
        chk("valid_lane", 181'(valid), 181'(exp_v));
        chk("payload", payload(), ref_mem[k]);
        case (mode)
          0, 4: lane_ready = '1;
          1: lane_ready = LANES'($urandom());
          2: begin
            if (k == 1 && hold < 10) begin
              lane_ready = ~exp_v;
              hold++;
            end else lane_ready = '1;
          end
          default: lane_ready = '0;
        endcase
        if ((lane_ready & exp_v) != '0) begin
          k++;
          xfer_prev = 1'b1;
          last_xfer = cyc;
          consec = 0;
        end else begin
          stalls++;
          consec++;
          if (consec == TIMEOUT) timed_out = 1'b1;
        end
      end else begin
        lane_ready = (mode == 3) ? '0 : LANES'($urandom());
      end
      if (mode == 4 && busy) begin
        cfg_we = 1'b1;
        cfg_addr = AW'($urandom());
        cfg_data = rand_rec();
      end else cfg_we = 1'b0;
      @(negedge clk);
    end
    cfg_we = 1'b0;
    lane_ready = '0;
    chk("done_seen", 181'(done_cyc != 0), 181'(1));
    chk("beats_issued", 181'(k), 181'(timed_out ? k : ne));
    chk("beat_cnt", 181'(beat_cnt), 181'(k));
    chk("error_flag", 181'(error), 181'(timed_out));
    chk("busy_cycles", 181'(busy_cyc), 181'(2 * k + stalls + 1 + int'(timed_out)));
    if (ne > 0 && !timed_out) chk("done_latency", 181'(done_cyc - last_xfer), 181'(2));
  endtask

  initial begin
    int st;
    repeat (3) @(negedge clk);
    check_all_zero("reset_held");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("reset_released");

    // Single known record.
    load(0, {144'h040d0a090200203a01007c414c4943000000, 16'h9520, 17'h00000, 3'h3, 1'b0});
    replay(1, 0, st);

    // Six beats, one per lane, back to back.
    load(1, {144'h494345275320414456454e54555245532049, 16'($urandom()), 17'h0001a,
             3'($urandom()), 1'b1});
    for (int i = 2; i < DEPTH; i++) load(i, rand_rec());
    replay(6, 0, st);

    // Lane pointer wraps after the last lane.
    replay(8, 0, st);

    // Target lane held off; other lanes ready must not complete the beat.
    replay(6, 2, st);
    chk("stall_cycles", 181'(st), 181'(10));

    // Timeout, then a fresh start clears the error.
    replay(3, 3, st);
    chk("timeout_stalls", 181'(st), 181'(TIMEOUT));
    chk("timeout_error", 181'(error), 181'(1));
    replay(2, 0, st);

    replay(0, 0, st);
    replay(20, 1, st);

    // Writes while busy must not touch the table; next replay reads the old contents.
    replay(16, 4, st);
    replay(16, 1, st);

    // Reset mid-replay.
    start = 1'b1;
    num_rec = 6;
    @(negedge clk);
    start = 1'b0;
    lane_ready = '1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("reset_mid_replay");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("quiet_after_reset", 181'({valid, busy}), '0);
    end
    lane_ready = '0;

    // Table survives reset.
    replay(5, 1, st);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
